// File: rtl/cdma_dc_pkg.sv
// rtl/cdma_dc_pkg.sv - shared types and constants for the CDMA direct-convolution request path
//
// Contents:
//   ATOM_SHIFT     log2 of the 32-byte atom size
//   DC_FIFO_DEPTH  depth of the DC latency FIFO (initial credit value)
//   dc_tag_t       tag pushed into the DC FIFO: {last, size}
//   dc_state_t     request-issuer FSM states
package cdma_dc_pkg;

   localparam int ATOM_SHIFT    = 5;
   localparam int DC_FIFO_DEPTH = 128;

   typedef struct packed {
      logic       last;
      logic [4:0] size;
   } dc_tag_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FLUSH = 2'd2
   } dc_state_t;

endpackage

// File: rtl/cdma_dc_credit_cnt.sv
// rtl/cdma_dc_credit_cnt.sv - up/down credit counter bounded by the DC FIFO depth
//
// Ports:
//   clk, reset_  clock, asynchronous active-low reset
//   dec          one credit consumed (DMA request accepted)
//   inc          one credit returned (FIFO popped on the read side)
//   cnt          available credits, resets to DEPTH
//   err          sticky: a credit came back while the count was already full
module cdma_dc_credit_cnt
   import cdma_dc_pkg::*;
#(
   parameter int DEPTH = DC_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       dec,
   input  logic       inc,
   output logic [7:0] cnt,
   output logic       err
);

   localparam logic [7:0] FULL = 8'(DEPTH);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt <= FULL;
         err <= 1'b0;
      end else begin
         if (inc && (cnt == FULL)) begin
            err <= 1'b1;
         end
         // A simultaneous consume and return cancel out; a return at full is dropped.
         if (dec && !inc) begin
            cnt <= cnt - 8'd1;
         end else if (inc && !dec && (cnt != FULL)) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/cdma_dc_req_issuer.sv
// rtl/cdma_dc_req_issuer.sv - splits a read command into DMA requests and pushes one tag per request into the DC FIFO
//
// Ports:
//   clk, reset_                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake; cmd_addr/cmd_num/cmd_size sampled on it
//   dma_rd_req_valid/ready           DMA read request handshake; addr/size of the request
//   fifo_wr_req/fifo_wr_ready        tag push toward the DC FIFO; fifo_wr_data = {last, size}
//   credit_ret                       one pulse per FIFO pop on the read side
//   credit_cnt/credit_err            available credits, sticky over-return flag
//   idle                             no command in flight and no tag held
module cdma_dc_req_issuer
   import cdma_dc_pkg::*;
#(
   parameter int AW    = 64,
   parameter int NUM_W = 13,
   parameter int DEPTH = DC_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [NUM_W-1:0] cmd_num,
   input  logic [4:0]       cmd_size,
   output logic             dma_rd_req_valid,
   input  logic             dma_rd_req_ready,
   output logic [AW-1:0]    dma_rd_req_addr,
   output logic [4:0]       dma_rd_req_size,
   output logic             fifo_wr_req,
   input  logic             fifo_wr_ready,
   output logic [5:0]       fifo_wr_data,
   input  logic             credit_ret,
   output logic [7:0]       credit_cnt,
   output logic             credit_err,
   output logic             idle
);

   dc_state_t        state;
   dc_state_t        state_nxt;
   logic [AW-1:0]    cur_addr;
   logic [AW-1:0]    addr_step;
   logic [NUM_W-1:0] remain;
   logic [4:0]       size_r;
   dc_tag_t          tag_r;
   logic             tag_vld;
   logic             tag_vld_nxt;
   logic             cmd_hs;
   logic             dma_hs;
   logic             tag_pop;
   logic             last_req;

   assign cmd_hs      = cmd_valid && cmd_ready;
   assign dma_hs      = dma_rd_req_valid && dma_rd_req_ready;
   assign tag_pop     = tag_vld && fifo_wr_ready;
   assign last_req    = (remain == '0);
   assign addr_step   = AW'({1'b0, size_r} + 6'd1) << ATOM_SHIFT;
   // A load and a pop in the same cycle leave the slot full with the new tag.
   assign tag_vld_nxt = dma_hs || (tag_vld && !tag_pop);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (cmd_hs)                  state_nxt = ST_REQ;
         ST_REQ:   if (dma_hs && last_req)      state_nxt = ST_FLUSH;
         ST_FLUSH: if (!tag_vld || tag_pop)     state_nxt = ST_IDLE;
         default:                               state_nxt = ST_IDLE;
      endcase
   end

   // A request is only offered when its tag is guaranteed a slot: either the
   // slot is empty or the held tag leaves this cycle.
   always_comb begin
      dma_rd_req_valid = (state == ST_REQ) && (credit_cnt != 8'd0) &&
                         (!tag_vld || fifo_wr_ready);
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cmd_ready <= 1'b1;
         idle      <= 1'b1;
         cur_addr  <= '0;
         remain    <= '0;
         size_r    <= '0;
         tag_r     <= '0;
         tag_vld   <= 1'b0;
      end else begin
         cmd_ready <= (state_nxt == ST_IDLE);
         idle      <= (state_nxt == ST_IDLE) && !tag_vld_nxt;
         if (cmd_hs) begin
            cur_addr <= cmd_addr;
            remain   <= cmd_num;
            size_r   <= cmd_size;
         end else if (dma_hs) begin
            cur_addr <= cur_addr + addr_step;
            if (!last_req) begin
               remain <= remain - NUM_W'(1);
            end
         end
         if (dma_hs) begin
            tag_r <= '{last: last_req, size: size_r};
         end
         tag_vld <= tag_vld_nxt;
      end
   end

   assign dma_rd_req_addr = cur_addr;
   assign dma_rd_req_size = size_r;
   assign fifo_wr_req     = tag_vld;
   assign fifo_wr_data    = tag_r;

   cdma_dc_credit_cnt #(
      .DEPTH (DEPTH)
   ) u_credit (
      .clk    (clk),
      .reset_ (reset_),
      .dec    (dma_hs),
      .inc    (credit_ret),
      .cnt    (credit_cnt),
      .err    (credit_err)
   );

endmodule

// File: tb/tb_cdma_dc_req_issuer.sv
// tb/tb_cdma_dc_req_issuer.sv - self-checking bench for cdma_dc_req_issuer
module tb_cdma_dc_req_issuer;

   localparam int DEPTH = 128;

   logic        clk = 1'b0;
   logic        reset_ = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [63:0] cmd_addr = '0;
   logic [12:0] cmd_num = '0;
   logic [4:0]  cmd_size = '0;
   logic        dma_rd_req_valid;
   logic        dma_rd_req_ready = 1'b0;
   logic [63:0] dma_rd_req_addr;
   logic [4:0]  dma_rd_req_size;
   logic        fifo_wr_req;
   logic        fifo_wr_ready = 1'b1;
   logic [5:0]  fifo_wr_data;
   logic        credit_ret = 1'b0;
   logic [7:0]  credit_cnt;
   logic        credit_err;
   logic        idle;

   int n_pass = 0;
   int n_total = 0;

   logic [63:0] dma_q[$];
   logic [4:0]  size_q[$];
   logic [5:0]  tag_q[$];
   int n_dma = 0;
   int n_pop = 0;
   int n_ret = 0;
   int m_credit = DEPTH;

   always #5 clk = ~clk;

   cdma_dc_req_issuer #(.AW(64), .NUM_W(13), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset_           (reset_),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_addr         (cmd_addr),
      .cmd_num          (cmd_num),
      .cmd_size         (cmd_size),
      .dma_rd_req_valid (dma_rd_req_valid),
      .dma_rd_req_ready (dma_rd_req_ready),
      .dma_rd_req_addr  (dma_rd_req_addr),
      .dma_rd_req_size  (dma_rd_req_size),
      .fifo_wr_req      (fifo_wr_req),
      .fifo_wr_ready    (fifo_wr_ready),
      .fifo_wr_data     (fifo_wr_data),
      .credit_ret       (credit_ret),
      .credit_cnt       (credit_cnt),
      .credit_err       (credit_err),
      .idle             (idle)
   );

   // Observer: just before each rising edge, record what that edge will accept.
   always begin
      @(negedge clk);
      #4;
      if (!reset_) begin
         n_dma = 0; n_pop = 0; n_ret = 0; m_credit = DEPTH;
      end else begin
         if (dma_rd_req_valid && dma_rd_req_ready) begin
            dma_q.push_back(dma_rd_req_addr);
            size_q.push_back(dma_rd_req_size);
            n_dma = n_dma + 1;
         end
         if (fifo_wr_req && fifo_wr_ready) begin
            tag_q.push_back(fifo_wr_data);
            n_pop = n_pop + 1;
         end
         if (credit_ret) n_ret = n_ret + 1;
         if (dma_rd_req_valid && dma_rd_req_ready && !credit_ret) m_credit = m_credit - 1;
         else if (credit_ret && !(dma_rd_req_valid && dma_rd_req_ready) && m_credit < DEPTH)
            m_credit = m_credit + 1;
      end
   end

   // Reference: request i of a command goes to a + i*(size+1)*32 with tag {i==num, size}.
   function automatic int first_bad(input logic [63:0] a, input int num, input logic [4:0] sz);
      logic [63:0] e;
      logic [5:0]  t;
      if (dma_q.size() != num + 1 || tag_q.size() != num + 1 || size_q.size() != num + 1) return -2;
      for (int i = 0; i <= num; i++) begin
         e = a + 64'(i) * ((64'(sz) + 64'd1) << 5);
         t = {(i == num), sz};
         if (dma_q[i] !== e || size_q[i] !== sz || tag_q[i] !== t) return i;
      end
      return -1;
   endfunction

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      a = {$urandom, $urandom};
      a[4:0] = '0;
      if ($urandom_range(0, 3) == 0) a[63:16] = '1;
      return a;
   endfunction

   task automatic send_cmd(input logic [63:0] a, input int num, input logic [4:0] sz);
      @(negedge clk);
      dma_q.delete(); size_q.delete(); tag_q.delete();
      cmd_valid = 1'b1; cmd_addr = a; cmd_num = 13'(num); cmd_size = sz;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr = {$urandom, $urandom}; cmd_num = 13'($urandom); cmd_size = 5'($urandom);
   endtask

   task automatic finish_run(input int p_dma, input int p_fifo, input int p_ret,
                             input int max_cyc, output bit timeout);
      timeout = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         dma_rd_req_ready = ($urandom_range(0, 99) < p_dma);
         fifo_wr_ready    = ($urandom_range(0, 99) < p_fifo);
         credit_ret       = (n_pop > n_ret) && ($urandom_range(0, 99) < p_ret);
         #1;
         if (idle && !credit_ret && n_ret >= n_pop) begin
            timeout = 1'b0;
            break;
         end
      end
      credit_ret = 1'b0;
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if ({cmd_ready, dma_rd_req_valid, fifo_wr_req, credit_err, idle} !== 5'b10001) $display("FAIL reset_flags: got %b need 10001", {cmd_ready, dma_rd_req_valid, fifo_wr_req, credit_err, idle});
      else n_pass++;
      n_total++;
      if (dma_rd_req_addr !== 64'd0 || dma_rd_req_size !== 5'd0 || fifo_wr_data !== 6'd0) $display("FAIL reset_data: got addr %h size %h tag %h need zeros", dma_rd_req_addr, dma_rd_req_size, fifo_wr_data);
      else n_pass++;
      reset_ = 1'b1;
      @(negedge clk);
      #1;
      n_total++;
      if (credit_cnt !== 8'd128 || idle !== 1'b1) $display("FAIL reset_credit: got credit %0d idle %b need 128 1", credit_cnt, idle);
      else n_pass++;
   endtask

   task automatic test_single();
      int r;
      dma_rd_req_ready = 1'b1; fifo_wr_ready = 1'b1;
      send_cmd(64'h1000, 0, 5'd3);
      #1;
      n_total++;
      if (dma_rd_req_valid !== 1'b1 || dma_rd_req_addr !== 64'h1000 || dma_rd_req_size !== 5'd3) $display("FAIL single_req: got v %b addr %h size %0d need 1 1000 3", dma_rd_req_valid, dma_rd_req_addr, dma_rd_req_size);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (fifo_wr_req !== 1'b1 || fifo_wr_data !== 6'h23 || credit_cnt !== 8'd127) $display("FAIL single_tag: got req %b tag %h credit %0d need 1 23 127", fifo_wr_req, fifo_wr_data, credit_cnt);
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if (cmd_ready !== 1'b1 || idle !== 1'b1 || fifo_wr_req !== 1'b0) $display("FAIL single_done: got ready %b idle %b req %b need 1 1 0", cmd_ready, idle, fifo_wr_req);
      else n_pass++;
      credit_ret = 1'b1;
      @(negedge clk); credit_ret = 1'b0; #1;
      n_total++;
      if (credit_cnt !== 8'd128) $display("FAIL single_credit: got %0d need 128", credit_cnt);
      else n_pass++;
      r = first_bad(64'h1000, 0, 5'd3);
      n_total++;
      if (r != -1) $display("FAIL single_seq: bad index %0d reqs %0d tags %0d need 1", r, dma_q.size(), tag_q.size());
      else n_pass++;
   endtask

   task automatic test_wrap();
      int r;
      bit to;
      send_cmd(64'hFFFF_FFFF_FFFF_FFE0, 3, 5'd0);
      finish_run(100, 100, 100, 200, to);
      r = first_bad(64'hFFFF_FFFF_FFFF_FFE0, 3, 5'd0);
      n_total++;
      if (to || r != -1) $display("FAIL wrap_seq: timeout %b bad index %0d reqs %0d tags %0d need 4", to, r, dma_q.size(), tag_q.size());
      else n_pass++;
      n_total++;
      if (credit_cnt !== 8'd128) $display("FAIL wrap_credit: got %0d need 128", credit_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] a;
      logic [4:0]  sz;
      int num, r;
      bit done, to, prev_hold, exp_tag, exp_valid;
      logic [5:0] prev_data;
      for (int k = 0; k < 8; k++) begin
         a = rand_addr(); sz = 5'($urandom); num = $urandom_range(0, 40);
         send_cmd(a, num, sz);
         done = 1'b0; prev_hold = 1'b0; prev_data = '0;
         for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            dma_rd_req_ready = ($urandom_range(0, 99) < 70);
            fifo_wr_ready    = ($urandom_range(0, 99) < 60);
            credit_ret       = (n_pop > n_ret) && ($urandom_range(0, 99) < 40);
            #1;
            exp_tag   = (n_dma != n_pop);
            exp_valid = (dma_q.size() <= num) && (m_credit != 0) && (!exp_tag || fifo_wr_ready);
            n_total++;
            if ({dma_rd_req_valid, fifo_wr_req, credit_cnt} !== {exp_valid, exp_tag, 8'(m_credit)}) $display("FAIL rand_cycle: got v %b req %b credit %0d need %b %b %0d", dma_rd_req_valid, fifo_wr_req, credit_cnt, exp_valid, exp_tag, m_credit);
            else n_pass++;
            if (prev_hold) begin
               n_total++;
               if (fifo_wr_data !== prev_data) $display("FAIL rand_hold: got tag %h need %h", fifo_wr_data, prev_data);
               else n_pass++;
            end
            prev_hold = fifo_wr_req && !fifo_wr_ready;
            prev_data = fifo_wr_data;
            if (idle && dma_q.size() == num + 1) begin
               done = 1'b1;
               break;
            end
         end
         credit_ret = 1'b0;
         r = first_bad(a, num, sz);
         n_total++;
         if (!done || r != -1) $display("FAIL rand_seq: done %b bad index %0d reqs %0d tags %0d need %0d", done, r, dma_q.size(), tag_q.size(), num + 1);
         else n_pass++;
      end
      finish_run(100, 100, 100, 400, to);
      n_total++;
      if (to || credit_cnt !== 8'd128) $display("FAIL rand_credit: timeout %b got %0d need 128", to, credit_cnt);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [63:0] a;
      logic [5:0]  held;
      int c0, r;
      bit seen, bad, to;
      a = rand_addr();
      dma_rd_req_ready = 1'b1; fifo_wr_ready = 1'b1;
      send_cmd(a, 5, 5'd1);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (fifo_wr_req) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      fifo_wr_ready = 1'b0;
      held = fifo_wr_data;
      c0 = dma_q.size();
      n_total++;
      if (!seen || held !== 6'h01 || c0 !== 1) $display("FAIL bp_first: seen %b tag %h reqs %0d need 1 01 1", seen, held, c0);
      else n_pass++;
      bad = 1'b0;
      #1;
      for (int k = 0; k < 10; k++) begin
         if (fifo_wr_req !== 1'b1 || fifo_wr_data !== held || dma_rd_req_valid !== 1'b0) bad = 1'b1;
         @(negedge clk); #2;
      end
      n_total++;
      if (bad || dma_q.size() !== c0) $display("FAIL bp_hold: unstable %b reqs %0d need 0 %0d", bad, dma_q.size(), c0);
      else n_pass++;
      fifo_wr_ready = 1'b1;
      #1;
      n_total++;
      if (dma_rd_req_valid !== 1'b1) $display("FAIL bp_resume: got valid %b need 1", dma_rd_req_valid);
      else n_pass++;
      finish_run(100, 100, 100, 200, to);
      r = first_bad(a, 5, 5'd1);
      n_total++;
      if (to || r != -1 || credit_cnt !== 8'd128) $display("FAIL bp_seq: timeout %b bad index %0d credit %0d need -1 128", to, r, credit_cnt);
      else n_pass++;
   endtask

   task automatic test_credit_exhaust();
      logic [63:0] a;
      logic [4:0]  sz;
      int r;
      bit to;
      a = rand_addr(); sz = 5'($urandom);
      dma_rd_req_ready = 1'b1; fifo_wr_ready = 1'b1;
      send_cmd(a, 199, sz);
      repeat (300) @(negedge clk);
      #1;
      n_total++;
      if (dma_q.size() !== 128 || credit_cnt !== 8'd0 || dma_rd_req_valid !== 1'b0) $display("FAIL exhaust_stop: reqs %0d credit %0d valid %b need 128 0 0", dma_q.size(), credit_cnt, dma_rd_req_valid);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); credit_ret = 1'b1;
         @(negedge clk); credit_ret = 1'b0;
      end
      repeat (10) @(negedge clk);
      #1;
      n_total++;
      if (dma_q.size() !== 133 || credit_cnt !== 8'd0) $display("FAIL exhaust_five: reqs %0d credit %0d need 133 0", dma_q.size(), credit_cnt);
      else n_pass++;
      finish_run(100, 100, 100, 2000, to);
      r = first_bad(a, 199, sz);
      n_total++;
      if (to || r != -1) $display("FAIL exhaust_seq: timeout %b bad index %0d reqs %0d need 200", to, r, dma_q.size());
      else n_pass++;
      n_total++;
      if (credit_cnt !== 8'd128 || credit_err !== 1'b0) $display("FAIL exhaust_credit: got %0d err %b need 128 0", credit_cnt, credit_err);
      else n_pass++;
   endtask

   task automatic test_simul_err();
      int c0;
      bit to;
      dma_rd_req_ready = 1'b1; fifo_wr_ready = 1'b1;
      send_cmd(rand_addr(), 200, 5'd0);
      repeat (200) @(negedge clk);
      credit_ret = 1'b1;
      @(negedge clk); credit_ret = 1'b0; #1;
      n_total++;
      if (credit_cnt !== 8'd1 || dma_rd_req_valid !== 1'b1) $display("FAIL simul_one: credit %0d valid %b need 1 1", credit_cnt, dma_rd_req_valid);
      else n_pass++;
      c0 = dma_q.size();
      credit_ret = 1'b1;
      @(negedge clk); credit_ret = 1'b0; #1;
      n_total++;
      if (credit_cnt !== 8'd1 || dma_q.size() !== c0 + 1) $display("FAIL simul_both: credit %0d reqs %0d need 1 %0d", credit_cnt, dma_q.size(), c0 + 1);
      else n_pass++;
      finish_run(100, 100, 100, 1000, to);
      n_total++;
      if (to || credit_cnt !== 8'd128 || credit_err !== 1'b0) $display("FAIL simul_drain: timeout %b credit %0d err %b need 128 0", to, credit_cnt, credit_err);
      else n_pass++;
      @(negedge clk); credit_ret = 1'b1;
      @(negedge clk); credit_ret = 1'b0; #1;
      n_total++;
      if (credit_err !== 1'b1 || credit_cnt !== 8'd128) $display("FAIL err_set: err %b credit %0d need 1 128", credit_err, credit_cnt);
      else n_pass++;
      repeat (5) @(negedge clk);
      #1;
      n_total++;
      if (credit_err !== 1'b1) $display("FAIL err_sticky: got %b need 1", credit_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [63:0] a;
      int r;
      bit hit, to;
      dma_rd_req_ready = 1'b1; fifo_wr_ready = 1'b1;
      send_cmd(rand_addr(), 50, 5'd2);
      hit = 1'b0;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (dma_q.size() == 9 && dma_rd_req_valid) begin
            reset_ = 1'b0;
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      #1;
      n_total++;
      if (!hit || {cmd_ready, dma_rd_req_valid, fifo_wr_req, credit_err, idle} !== 5'b10001) $display("FAIL midrst_flags: hit %b got %b need 10001", hit, {cmd_ready, dma_rd_req_valid, fifo_wr_req, credit_err, idle});
      else n_pass++;
      n_total++;
      if (dma_rd_req_addr !== 64'd0 || dma_rd_req_size !== 5'd0 || fifo_wr_data !== 6'd0 || credit_cnt !== 8'd128) $display("FAIL midrst_data: addr %h size %h tag %h credit %0d need 0 0 0 128", dma_rd_req_addr, dma_rd_req_size, fifo_wr_data, credit_cnt);
      else n_pass++;
      @(negedge clk);
      @(negedge clk); reset_ = 1'b1;
      a = rand_addr();
      send_cmd(a, 2, 5'd7);
      finish_run(100, 100, 100, 200, to);
      r = first_bad(a, 2, 5'd7);
      n_total++;
      if (to || r != -1 || credit_cnt !== 8'd128) $display("FAIL midrst_rerun: timeout %b bad index %0d credit %0d need -1 128", to, r, credit_cnt);
      else n_pass++;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_random();
      test_backpressure();
      test_credit_exhaust();
      test_simul_err();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
